// File: rtl/serial_tx_sched_pkg.sv
// Shared definitions for the serial transmit scheduler: line-sequencer
// state encoding and the requester identifiers used for arbitration.
package serial_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/serial_tx_sched_shift_register.sv
// Shift register with a parallel-load path. When enabled it either loads
// DATA_in (PARALLEL_EN=1) or shifts right by one, taking bit_in into the MSB.
// bit_out is the current LSB.
module shift_register #(
   parameter int bits = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            PARALLEL_EN,
   input  logic [bits-1:0] DATA_in,
   input  logic            bit_in,
   output logic [bits-1:0] DATA_out,
   output logic            bit_out
);

   // Word register: synchronous active-low clear, then load or shift right.
   always_ff @(posedge clk) begin
      if (!rst) begin
         DATA_out <= '0;
      end else if (enable) begin
         if (PARALLEL_EN) begin
            DATA_out <= DATA_in;
         end else begin
            DATA_out <= {bit_in, DATA_out[bits-1:1]};
         end
      end
   end

   assign bit_out = DATA_out[0];

endmodule

// File: rtl/serial_tx_sched.sv
// Two-requester UART-style transmit scheduler. Round-robin grants load the
// winning word into the shift register; the sequencer then emits start bit,
// data bits LSB first and stop bit, one symbol per bit-rate tick.
module serial_tx_sched
   import serial_tx_sched_pkg::*;
#(
   parameter int bits = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            req0_valid,
   input  logic [bits-1:0] req0_data,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [bits-1:0] req1_data,
   output logic            req1_ready,
   output logic            tx,
   output logic            busy,
   output logic            grant_id
);

   localparam int CNT_W = (bits > 1) ? $clog2(bits) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(bits - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
   logic             tx_q, tx_nx;
   logic             last_grant, last_grant_nx;
   logic             grant_id_q, grant_id_nx;

   logic             sr_en;
   logic             sr_par;
   logic [bits-1:0]  sr_din;
   logic [bits-1:0]  shift_q;
   logic             sr_bit_out;

   logic             grant_ok;
   logic             win;

   // Only the two low word bits drive the line; the rest are observed here
   // so the unused upper bits and bit_out do not dangle.
   logic             unused_bits;
   assign unused_bits = ^{shift_q, sr_bit_out};

   shift_register #(
      .bits (bits)
   ) u_shift (
      .clk         (clk),
      .rst         (rst),
      .enable      (sr_en),
      .PARALLEL_EN (sr_par),
      .DATA_in     (sr_din),
      .bit_in      (1'b1),
      .DATA_out    (shift_q),
      .bit_out     (sr_bit_out)
   );

   // Arbitration: a grant may only happen on a tick between frames; when
   // both requesters are valid the one not served last time wins.
   always_comb begin
      grant_ok = rst && tick && ((state == IDLE) || (state == STOP)) &&
                 (req0_valid || req1_valid);
      if (req0_valid && req1_valid) begin
         win = ~last_grant;
      end else if (req0_valid) begin
         win = REQ0;
      end else begin
         win = REQ1;
      end
   end

   // Next-state, line symbol, shift control and ready handshake.
   always_comb begin
      state_nx      = state;
      bit_cnt_nx    = bit_cnt;
      tx_nx         = tx_q;
      last_grant_nx = last_grant;
      grant_id_nx   = grant_id_q;
      sr_en         = 1'b0;
      sr_par        = 1'b0;
      sr_din        = req0_data;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;

      if (tick) begin
         case (state)
            IDLE, STOP: begin
               if (grant_ok) begin
                  req0_ready    = (win == REQ0);
                  req1_ready    = (win == REQ1);
                  sr_en         = 1'b1;
                  sr_par        = 1'b1;
                  sr_din        = (win == REQ1) ? req1_data : req0_data;
                  last_grant_nx = win;
                  grant_id_nx   = win;
                  tx_nx         = 1'b0;
                  state_nx      = START;
               end else if (state == STOP) begin
                  tx_nx    = 1'b1;
                  state_nx = IDLE;
               end
            end
            START: begin
               tx_nx      = shift_q[0];
               bit_cnt_nx = '0;
               state_nx   = DATA;
            end
            DATA: begin
               if (bit_cnt == LAST_BIT) begin
                  tx_nx    = 1'b1;
                  state_nx = STOP;
               end else begin
                  sr_en      = 1'b1;
                  tx_nx      = shift_q[1];
                  bit_cnt_nx = bit_cnt + 1'b1;
               end
            end
            default: begin
               state_nx = IDLE;
               tx_nx    = 1'b1;
            end
         endcase
      end
   end

   // Sequencer registers; a synchronous reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         tx_q       <= 1'b1;
         last_grant <= REQ1;
         grant_id_q <= REQ0;
      end else begin
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         tx_q       <= tx_nx;
         last_grant <= last_grant_nx;
         grant_id_q <= grant_id_nx;
      end
   end

   assign tx       = tx_q;
   assign busy     = (state != IDLE);
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_tx_sched.sv
// Randomized self-checking bench for serial_tx_sched. The reference model
// tracks the frame as a symbol position (start, data bits, stop) plus the
// round-robin history, and predicts ready, tx, busy and grant_id each clock.
module tb_serial_tx_sched;

   localparam int BITS  = 8;
   localparam int FRAME = BITS + 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            tick;
   logic            v0, v1;
   logic [BITS-1:0] d0, d1;
   logic            r0, r1;
   logic            tx, busy, gid;

   serial_tx_sched #(
      .bits (BITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .req0_valid (v0),
      .req0_data  (d0),
      .req0_ready (r0),
      .req1_valid (v1),
      .req1_data  (d1),
      .req1_ready (r1),
      .tx         (tx),
      .busy       (busy),
      .grant_id   (gid)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: -1 idle, else index of the symbol on the line.
   int              m_pos = -1;
   logic            m_last = 1'b1;
   logic            m_gid = 1'b0;
   logic [BITS-1:0] m_word = '0;

   int              tick_mode = 4;   // 0 manual, >0 period in clk, -1 random
   int              tick_cnt = 0;
   int              rdy_cnt0 = 0;
   int              rdy_cnt1 = 0;
   int              rec_left = 0;
   logic [FRAME-1:0] seq = '0;
   int              grants[$];

   task automatic check_vec(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_sym();
      if (m_pos < 0)          return 1'b1;
      if (m_pos == 0)         return 1'b0;
      if (m_pos == FRAME - 1) return 1'b1;
      return m_word[m_pos-1];
   endfunction

   task automatic step();
      logic grant_now;
      logic w;
      @(negedge clk);
      grant_now = rst && tick && (m_pos < 0 || m_pos == FRAME - 1) && (v0 || v1);
      w = (v0 && v1) ? ~m_last : (v0 ? 1'b0 : 1'b1);
      check_vec("ready0", r0, grant_now && (w == 1'b0));
      check_vec("ready1", r1, grant_now && (w == 1'b1));
      if (r0) rdy_cnt0++;
      if (r1) rdy_cnt1++;
      if (r0 || r1) grants.push_back(r1 ? 1 : 0);
      @(posedge clk);
      if (!rst) begin
         m_pos  = -1;
         m_last = 1'b1;
         m_gid  = 1'b0;
      end else if (tick) begin
         if (grant_now) begin
            m_pos    = 0;
            m_word   = w ? d1 : d0;
            m_last   = w;
            m_gid    = w;
            rec_left = FRAME;
         end else if (m_pos == FRAME - 1) begin
            m_pos = -1;
         end else if (m_pos >= 0) begin
            m_pos++;
         end
      end
      #1;
      check_vec("tx", tx, m_sym());
      check_vec("busy", busy, m_pos >= 0);
      check_vec("grant_id", gid, m_gid);
      if (tick && rec_left > 0) begin
         seq = {seq[FRAME-2:0], tx};
         rec_left--;
      end
      if (tick_mode > 0) begin
         tick_cnt++;
         tick = (tick_cnt % tick_mode) == 0;
      end else if (tick_mode < 0) begin
         tick = ($urandom_range(0, 2) == 0);
      end else begin
         tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; tick = 1'b0;
      v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;

      // Reset state
      repeat (3) step();
      check_vec("rst_tx", tx, 1'b1);
      check_vec("rst_busy", busy, 1'b0);
      check_vec("rst_gid", gid, 1'b0);
      rst = 1'b1;

      // Single requester 0xA5
      d0 = 8'hA5; v0 = 1'b1; rdy_cnt0 = 0; seq = '0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (rdy_cnt0 > 0) v0 = 1'b0;
      end
      check_vec("t1_seq", seq, 10'b0101001011);
      check_vec("t1_ready_cnt", rdy_cnt0, 1);

      // Both held: alternating grants, back-to-back frames
      do_reset();
      grants.delete();
      d0 = 8'h11; d1 = 8'h22; v0 = 1'b1; v1 = 1'b1;
      repeat (170) step();
      v0 = 1'b0; v1 = 1'b0;
      repeat (50) step();
      check_vec("t3_ngrants", grants.size() >= 4, 1);
      if (grants.size() >= 4)
         check_vec("t3_order", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]},
                   4'b0101);

      // Requester 1 alone with 0x00, tick stalled after the grant
      tick_mode = 0; tick = 1'b0;
      do_reset();
      d1 = 8'h00; v1 = 1'b1;
      tick = 1'b0; step();
      tick = 1'b1; step();
      v1 = 1'b0;
      repeat (50) step();
      check_vec("t4_hold_tx", tx, 1'b0);
      tick_mode = 4;
      repeat (50) step();

      // Reset in the middle of data bits
      do_reset();
      d0 = 8'hFF; v0 = 1'b1; rdy_cnt0 = 0;
      begin
         int guard = 0;
         while (m_pos != 5 && guard < 100) begin
            step();
            if (rdy_cnt0 > 0) v0 = 1'b0;
            guard++;
         end
         check_vec("t5_reach", guard < 100, 1);
      end
      rst = 1'b0;
      step();
      check_vec("t5_tx_rst", tx, 1'b1);
      check_vec("t5_busy_rst", busy, 1'b0);
      rst = 1'b1;
      d0 = 8'h3C; v0 = 1'b1; rdy_cnt0 = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (rdy_cnt0 > 0) v0 = 1'b0;
      end
      check_vec("t5_ready_cnt", rdy_cnt0, 1);

      // Valid only on non-tick cycles: never granted
      do_reset();
      rdy_cnt0 = 0; rdy_cnt1 = 0;
      for (int i = 0; i < 60; i++) begin
         v0 = !tick && $urandom_range(0, 1) == 1;
         v1 = !tick && $urandom_range(0, 1) == 1;
         d0 = BITS'($urandom);
         d1 = BITS'($urandom);
         step();
      end
      check_vec("t6_no_ready", rdy_cnt0 + rdy_cnt1, 0);

      // Random traffic, random ticks, occasional reset
      tick_mode = -1;
      for (int i = 0; i < 2000; i++) begin
         v0  = ($urandom_range(0, 3) != 0);
         v1  = ($urandom_range(0, 3) != 0);
         d0  = BITS'($urandom);
         d1  = BITS'($urandom);
         rst = ($urandom_range(0, 199) != 0);
         step();
      end
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
      repeat (80) step();
      check_vec("end_idle_tx", tx, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
